// File: rtl/dmem_lane_if.sv
// Core-side request/response handshake plus the byte-lane BRAM port.
// The slave modport belongs to dmem_lane_ctrl. The master modport belongs to the core and banks.
interface dmem_lane_if #(
    parameter int unsigned AddrWidth = 13
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [AddrWidth-1:0] req_addr;
    logic [31:0]          req_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    logic [AddrWidth-1:0] bram_w_addr;
    logic [AddrWidth-1:0] bram_r_addr;
    logic [3:0]           bram_write_en;
    logic [3:0]           bram_read_en;
    logic [31:0]          bram_din;
    logic [31:0]          bram_dout;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, bram_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bram_w_addr, bram_r_addr, bram_write_en, bram_read_en, bram_din
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, bram_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bram_w_addr, bram_r_addr, bram_write_en, bram_read_en, bram_din
    );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Turns one RV32 load/store request into per-lane controls for four 8-bit BRAM banks.
// It returns the extended load result, or a store ack, with a misalignment error flag.
module dmem_lane_ctrl #(
    parameter int unsigned AddrWidth = 13
) (
    input logic        clk_i,
    input logic        rst_i,
    dmem_lane_if.slave bus_io
);
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic        legal;
    logic        in_access;
    logic [3:0]  lane_mask;
    logic [31:0] store_din;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign in_access = (state_q == StAccess);

    // Decode the lane mask and legality from the registered request only.
    always_comb begin
        legal     = 1'b0;
        lane_mask = 4'b0000;
        case (funct3_q)
            3'd0, 3'd4: begin
                legal     = (funct3_q == 3'd0) || !we_q;
                lane_mask = 4'b0001 << addr_q[1:0];
            end
            3'd1, 3'd5: begin
                legal     = !addr_q[0] && ((funct3_q == 3'd1) || !we_q);
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal     = (addr_q[1:0] == 2'b00);
                lane_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        store_din = wdata_q;
        case (funct3_q[1:0])
            2'd0:    store_din = {4{wdata_q[7:0]}};
            2'd1:    store_din = {2{wdata_q[15:0]}};
            default: store_din = wdata_q;
        endcase
    end

    always_comb begin
        byte_sel = bus_io.bram_dout[7:0];
        case (addr_q[1:0])
            2'd0: byte_sel = bus_io.bram_dout[7:0];
            2'd1: byte_sel = bus_io.bram_dout[15:8];
            2'd2: byte_sel = bus_io.bram_dout[23:16];
            2'd3: byte_sel = bus_io.bram_dout[31:24];
            default: ;
        endcase
        half_sel = addr_q[1] ? bus_io.bram_dout[31:16] : bus_io.bram_dout[15:0];
        load_val = 32'h0;
        case (funct3_q)
            3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
            3'd2:    load_val = bus_io.bram_dout;
            3'd4:    load_val = {24'h0, byte_sel};
            3'd5:    load_val = {16'h0, half_sel};
            default: load_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    we_d     = bus_io.req_we;
                    funct3_d = bus_io.req_funct3;
                    addr_d   = bus_io.req_addr;
                    wdata_d  = bus_io.req_wdata;
                    state_d  = StAccess;
                end
            end
            StAccess: begin
                // Bank DOUT was updated on this cycle's negedge, so it is valid at this edge.
                rdata_d = (legal && !we_q) ? load_val : 32'h0;
                err_d   = !legal;
                state_d = StResp;
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bank controls are decoded from state_q, so reset drops them without waiting for an edge.
    assign bus_io.req_ready     = (state_q == StIdle);
    assign bus_io.rsp_valid     = (state_q == StResp);
    assign bus_io.rsp_rdata     = rdata_q;
    assign bus_io.rsp_err       = err_q;
    assign bus_io.bram_w_addr   = in_access ? addr_q : '0;
    assign bus_io.bram_r_addr   = in_access ? addr_q : '0;
    assign bus_io.bram_din      = in_access ? store_din : 32'h0;
    assign bus_io.bram_write_en = (in_access && legal && we_q) ? lane_mask : 4'b0000;
    assign bus_io.bram_read_en  = (in_access && legal && !we_q) ? lane_mask : 4'b0000;
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench for dmem_lane_ctrl, with a four-bank negedge BRAM model behind the lane port.
module tb_dmem_lane_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    dmem_lane_if #(.AddrWidth(13)) bus ();

    dmem_lane_ctrl #(.AddrWidth(13)) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [4][2048];
    logic [31:0] bank_dout;
    assign bus.bram_dout = bank_dout;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.bram_write_en[i]) mem[i][bus.bram_w_addr[12:2]] <= bus.bram_din[8*i +: 8];
            if (bus.bram_read_en[i])  bank_dout[8*i +: 8] <= mem[i][bus.bram_r_addr[12:2]];
        end
    end

    // Values observed during ACCESS, during RESP, and one edge after the response.
    logic [3:0]  acc_we, acc_re;
    logic [31:0] acc_din;
    logic [12:0] acc_waddr, acc_raddr;
    logic        acc_req_ready, acc_rsp_valid;
    logic        rsp_valid_s, rsp_err_s;
    logic [31:0] rsp_rdata_s;
    logic [3:0]  rsp_en_s;
    logic        post_valid, post_err, post_ready;
    logic [31:0] post_rdata;

    // Called #1 after a posedge with the DUT idle. Returns #1 after the edge that enters RESP.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [12:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk); #1;
        // Scramble the request inputs to show that the controller uses only its registered copy.
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'd7;
        bus.req_addr   = ~addr;
        bus.req_wdata  = ~wdata;
        acc_we        = bus.bram_write_en;
        acc_re        = bus.bram_read_en;
        acc_din       = bus.bram_din;
        acc_waddr     = bus.bram_w_addr;
        acc_raddr     = bus.bram_r_addr;
        acc_req_ready = bus.req_ready;
        acc_rsp_valid = bus.rsp_valid;
        @(posedge clk); #1;
        rsp_valid_s = bus.rsp_valid;
        rsp_err_s   = bus.rsp_err;
        rsp_rdata_s = bus.rsp_rdata;
        rsp_en_s    = bus.bram_write_en | bus.bram_read_en;
    endtask

    task automatic finish_rsp();
        @(posedge clk); #1;
        post_valid = bus.rsp_valid;
        post_err   = bus.rsp_err;
        post_rdata = bus.rsp_rdata;
        post_ready = bus.req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rsp got v=%b e=%b d=%h want 0 0 0", bus.rsp_valid, bus.rsp_err,
                     bus.rsp_rdata);
        end
        n_cmp++;
        if (bus.bram_write_en !== 4'h0 || bus.bram_read_en !== 4'h0 || bus.bram_din !== 32'h0
            || bus.bram_w_addr !== 13'h0 || bus.bram_r_addr !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_bram got we=%h re=%h din=%h wa=%h ra=%h want all 0",
                     bus.bram_write_en, bus.bram_read_en, bus.bram_din, bus.bram_w_addr,
                     bus.bram_r_addr);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 1", bus.req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        issue(1'b1, 3'd2, 13'h010, 32'hDEADBEEF);
        n_cmp++;
        if (acc_we !== 4'b1111 || acc_re !== 4'b0000 || acc_din !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL sw_lanes got we=%b re=%b din=%h want 1111 0000 deadbeef", acc_we, acc_re,
                     acc_din);
        end
        n_cmp++;
        if (acc_waddr !== 13'h010 || acc_raddr !== 13'h010) begin
            n_bad++;
            $display("FAIL sw_addr got wa=%h ra=%h want 010 010", acc_waddr, acc_raddr);
        end
        n_cmp++;
        if (acc_req_ready !== 1'b0 || acc_rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_access_hs got ready=%b rsp_valid=%b want 0 0", acc_req_ready,
                     acc_rsp_valid);
        end
        n_cmp++;
        if (rsp_valid_s !== 1'b1 || rsp_err_s !== 1'b0 || rsp_rdata_s !== 32'h0
            || rsp_en_s !== 4'h0) begin
            n_bad++;
            $display("FAIL sw_ack got v=%b e=%b d=%h en=%h want 1 0 0 0", rsp_valid_s, rsp_err_s,
                     rsp_rdata_s, rsp_en_s);
        end
        finish_rsp();
        n_cmp++;
        if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL sw_idle got v=%b ready=%b want 0 1", post_valid, post_ready);
        end
    endtask

    task automatic test_load_byte();
        issue(1'b0, 3'd0, 13'h013, 32'h0);
        n_cmp++;
        if (acc_re !== 4'b1000 || acc_we !== 4'b0000 || rsp_rdata_s !== 32'hFFFFFFDE) begin
            n_bad++;
            $display("FAIL lb_013 got re=%b we=%b d=%h want 1000 0000 ffffffde", acc_re, acc_we,
                     rsp_rdata_s);
        end
        finish_rsp();
        issue(1'b0, 3'd4, 13'h013, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'h000000DE || rsp_err_s !== 1'b0) begin
            n_bad++;
            $display("FAIL lbu_013 got d=%h e=%b want 000000de 0", rsp_rdata_s, rsp_err_s);
        end
        finish_rsp();
        issue(1'b0, 3'd0, 13'h011, 32'h0);
        n_cmp++;
        if (acc_re !== 4'b0010 || rsp_rdata_s !== 32'hFFFFFFBE) begin
            n_bad++;
            $display("FAIL lb_011 got re=%b d=%h want 0010 ffffffbe", acc_re, rsp_rdata_s);
        end
        finish_rsp();
    endtask

    task automatic test_half_and_byte_store();
        issue(1'b1, 3'd1, 13'h016, 32'h00001234);
        n_cmp++;
        if (acc_we !== 4'b1100 || acc_din !== 32'h12341234) begin
            n_bad++;
            $display("FAIL sh_016 got we=%b din=%h want 1100 12341234", acc_we, acc_din);
        end
        finish_rsp();
        issue(1'b0, 3'd1, 13'h016, 32'h0);
        n_cmp++;
        if (acc_re !== 4'b1100 || rsp_rdata_s !== 32'h00001234) begin
            n_bad++;
            $display("FAIL lh_016 got re=%b d=%h want 1100 00001234", acc_re, rsp_rdata_s);
        end
        finish_rsp();
        issue(1'b1, 3'd1, 13'h014, 32'hFFFF8001);
        n_cmp++;
        if (acc_we !== 4'b0011 || acc_din !== 32'h80018001) begin
            n_bad++;
            $display("FAIL sh_014 got we=%b din=%h want 0011 80018001", acc_we, acc_din);
        end
        finish_rsp();
        issue(1'b0, 3'd1, 13'h014, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'hFFFF8001) begin
            n_bad++;
            $display("FAIL lh_014 got %h want ffff8001", rsp_rdata_s);
        end
        finish_rsp();
        issue(1'b0, 3'd5, 13'h014, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'h00008001) begin
            n_bad++;
            $display("FAIL lhu_014 got %h want 00008001", rsp_rdata_s);
        end
        finish_rsp();
        issue(1'b0, 3'd2, 13'h014, 32'h0);
        n_cmp++;
        if (acc_re !== 4'b1111 || rsp_rdata_s !== 32'h12348001) begin
            n_bad++;
            $display("FAIL lw_014 got re=%b d=%h want 1111 12348001", acc_re, rsp_rdata_s);
        end
        finish_rsp();
        issue(1'b1, 3'd0, 13'h011, 32'h12345677);
        n_cmp++;
        if (acc_we !== 4'b0010 || acc_din !== 32'h77777777) begin
            n_bad++;
            $display("FAIL sb_011 got we=%b din=%h want 0010 77777777", acc_we, acc_din);
        end
        finish_rsp();
        issue(1'b0, 3'd2, 13'h010, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'hDEAD77EF) begin
            n_bad++;
            $display("FAIL lw_010 got %h want dead77ef", rsp_rdata_s);
        end
        finish_rsp();
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'd2, 13'h012, 32'h0);
        n_cmp++;
        if (acc_we !== 4'h0 || acc_re !== 4'h0) begin
            n_bad++;
            $display("FAIL lw_mis_en got we=%b re=%b want 0000 0000", acc_we, acc_re);
        end
        n_cmp++;
        if (rsp_valid_s !== 1'b1 || rsp_err_s !== 1'b1 || rsp_rdata_s !== 32'h0) begin
            n_bad++;
            $display("FAIL lw_mis_rsp got v=%b e=%b d=%h want 1 1 0", rsp_valid_s, rsp_err_s,
                     rsp_rdata_s);
        end
        finish_rsp();
        n_cmp++;
        if (post_err !== 1'b0 || post_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear got e=%b v=%b want 0 0", post_err, post_valid);
        end
        issue(1'b1, 3'd4, 13'h010, 32'h0BADF00D);
        n_cmp++;
        if (acc_we !== 4'h0 || rsp_err_s !== 1'b1) begin
            n_bad++;
            $display("FAIL sbu_illegal got we=%b e=%b want 0000 1", acc_we, rsp_err_s);
        end
        finish_rsp();
        issue(1'b0, 3'd3, 13'h010, 32'h0);
        n_cmp++;
        if (acc_re !== 4'h0 || rsp_err_s !== 1'b1 || rsp_rdata_s !== 32'h0) begin
            n_bad++;
            $display("FAIL f3_3_illegal got re=%b e=%b d=%h want 0000 1 0", acc_re, rsp_err_s,
                     rsp_rdata_s);
        end
        finish_rsp();
        issue(1'b0, 3'd5, 13'h011, 32'h0);
        n_cmp++;
        if (acc_re !== 4'h0 || rsp_err_s !== 1'b1) begin
            n_bad++;
            $display("FAIL lhu_mis got re=%b e=%b want 0000 1", acc_re, rsp_err_s);
        end
        finish_rsp();
        issue(1'b0, 3'd2, 13'h010, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'hDEAD77EF || rsp_err_s !== 1'b0) begin
            n_bad++;
            $display("FAIL after_illegal got d=%h e=%b want dead77ef 0", rsp_rdata_s, rsp_err_s);
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 3'd2, 13'h014, 32'h0);
        // A competing request during the hold must not be accepted.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 13'h014;
        bus.req_wdata  = 32'h55555555;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h12348001
                || bus.req_ready !== 1'b0 || bus.bram_write_en !== 4'h0) begin
                n_bad++;
                $display("FAIL hold_%0d got v=%b d=%h ready=%b we=%b want 1 12348001 0 0000", k,
                         bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.bram_write_en);
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL release got v=%b ready=%b d=%h want 0 1 0", bus.rsp_valid,
                     bus.req_ready, bus.rsp_rdata);
        end
        issue(1'b0, 3'd2, 13'h014, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'h12348001) begin
            n_bad++;
            $display("FAIL no_stray_write got %h want 12348001", rsp_rdata_s);
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_access();
        issue(1'b1, 3'd2, 13'h020, 32'h11223344);
        finish_rsp();
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 13'h020;
        bus.req_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.bram_write_en !== 4'b1111) begin
            n_bad++;
            $display("FAIL rst_pre_we got %b want 1111", bus.bram_write_en);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.bram_write_en !== 4'h0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid got we=%b v=%b ready=%b want 0000 0 1", bus.bram_write_en,
                     bus.rsp_valid, bus.req_ready);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 3'd2, 13'h020, 32'h0);
        n_cmp++;
        if (rsp_rdata_s !== 32'h11223344 || rsp_err_s !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_old_value got d=%h e=%b want 11223344 0", rsp_rdata_s, rsp_err_s);
        end
        finish_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached without completing the test sequence");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_store_word();
        test_load_byte();
        test_half_and_byte_store();
        test_illegal();
        test_backpressure();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
